// File: rtl/onehot_scan_encoder.sv
// Sequential priority scan encoder: captures an N-bit request vector through a
// valid/ready handshake and emits the index of every set bit, one per output beat.
module onehot_scan_encoder #(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b0,
  localparam int IDX_W    = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N-1:0]     in_vec,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             out_none,
  output logic [IDX_W:0]   out_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     pending_q, pending_d;
  logic [IDX_W:0]   cnt_q, cnt_d;
  logic             none_q, none_d;

  logic [IDX_W-1:0] sel_idx_s;
  logic             last_s;
  logic [N-1:0]     clr_mask_s;

  function automatic logic [IDX_W:0] popcount(input logic [N-1:0] v);
    logic [IDX_W:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + (IDX_W+1)'(v[i]);
    end
    return c;
  endfunction

  // Descending walk so the lowest set bit is the last one written.
  function automatic logic [IDX_W-1:0] low_idx(input logic [N-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  function automatic logic [IDX_W-1:0] high_idx(input logic [N-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  // Decode the current beat from the pending register.
  always_comb begin
    if (MSB_FIRST) begin
      sel_idx_s = high_idx(pending_q);
    end else begin
      sel_idx_s = low_idx(pending_q);
    end
    last_s     = (popcount(pending_q) == (IDX_W+1)'(1));
    clr_mask_s = {{(N-1){1'b0}}, 1'b1} << sel_idx_s;
  end

  // Output drive; out_idx is forced to zero outside SCAN so it never floats X.
  always_comb begin
    in_ready  = en && (state_q == IDLE);
    out_valid = (state_q == SCAN);
    out_idx   = (state_q == SCAN) ? sel_idx_s : '0;
    out_last  = (state_q == SCAN) && last_s;
    out_none  = none_q;
    out_cnt   = cnt_q;
  end

  // Next-state logic: enable outranks the handshakes.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    none_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && in_valid) begin
          if (in_vec != '0) begin
            pending_d = in_vec;
            cnt_d     = popcount(in_vec);
            state_d   = SCAN;
          end else begin
            cnt_d  = '0;
            none_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (!en) begin
          pending_d = '0;
          state_d   = IDLE;
        end else if (out_ready) begin
          pending_d = pending_q & ~clr_mask_s;
          if (last_s) begin
            state_d = IDLE;
          end else begin
            state_d = SCAN;
          end
        end else begin
          state_d = SCAN;
        end
      end
      default: begin
        pending_d = '0;
        state_d   = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      cnt_q     <= '0;
      none_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      none_q    <= none_d;
    end
  end

endmodule

// File: tb/tb_onehot_scan_encoder.sv
// Scoreboard bench: one LSB-first and one MSB-first encoder share all inputs;
// a queue-based reference model predicts every beat and is checked each cycle.
module tb_onehot_scan_encoder;

  localparam int N     = 8;
  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             rst, en, in_valid, out_ready;
  logic [N-1:0]     in_vec;
  logic             in_ready_l, out_valid_l, out_last_l, out_none_l;
  logic             in_ready_h, out_valid_h, out_last_h, out_none_h;
  logic [IDX_W-1:0] out_idx_l, out_idx_h;
  logic [IDX_W:0]   out_cnt_l, out_cnt_h;

  int tests = 0;
  int fails = 0;
  int q_lo[$];
  int q_hi[$];
  int exp_cnt  = 0;
  int exp_none = 0;
  bit armed    = 1'b0;

  onehot_scan_encoder #(.N(N), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .en(en), .in_vec(in_vec), .in_valid(in_valid),
    .in_ready(in_ready_l), .out_idx(out_idx_l), .out_valid(out_valid_l),
    .out_ready(out_ready), .out_last(out_last_l), .out_none(out_none_l),
    .out_cnt(out_cnt_l)
  );

  onehot_scan_encoder #(.N(N), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .en(en), .in_vec(in_vec), .in_valid(in_valid),
    .in_ready(in_ready_h), .out_idx(out_idx_h), .out_valid(out_valid_h),
    .out_ready(out_ready), .out_last(out_last_h), .out_none(out_none_h),
    .out_cnt(out_cnt_h)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare outputs against the model, then advance the model by one edge.
  always @(negedge clk) begin
    logic busy;
    busy = (q_lo.size() != 0);
    if (armed) begin
      chk("in_ready_lsb",  32'(in_ready_l),  32'(en && !busy));
      chk("in_ready_msb",  32'(in_ready_h),  32'(en && !busy));
      chk("out_valid_lsb", 32'(out_valid_l), 32'(busy));
      chk("out_valid_msb", 32'(out_valid_h), 32'(busy));
      chk("out_idx_lsb",   32'(out_idx_l),   busy ? 32'(q_lo[0]) : 32'd0);
      chk("out_idx_msb",   32'(out_idx_h),   busy ? 32'(q_hi[0]) : 32'd0);
      chk("out_last_lsb",  32'(out_last_l),  32'(busy && q_lo.size() == 1));
      chk("out_last_msb",  32'(out_last_h),  32'(busy && q_hi.size() == 1));
      chk("out_none_lsb",  32'(out_none_l),  32'(exp_none));
      chk("out_none_msb",  32'(out_none_h),  32'(exp_none));
      chk("out_cnt_lsb",   32'(out_cnt_l),   32'(exp_cnt));
      chk("out_cnt_msb",   32'(out_cnt_h),   32'(exp_cnt));
    end
    exp_none = 0;
    if (rst) begin
      armed = 1'b1;
      q_lo.delete();
      q_hi.delete();
      exp_cnt = 0;
    end else if (busy) begin
      if (!en) begin
        q_lo.delete();
        q_hi.delete();
      end else if (out_ready) begin
        void'(q_lo.pop_front());
        void'(q_hi.pop_front());
      end
    end else if (en && in_valid) begin
      for (int i = 0; i < N; i++) if (in_vec[i]) q_lo.push_back(i);
      for (int i = N - 1; i >= 0; i--) if (in_vec[i]) q_hi.push_back(i);
      exp_cnt = q_lo.size();
      if (exp_cnt == 0) exp_none = 1;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic [N-1:0] v);
    in_vec   = v;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q_lo.size() != 0 && n < 64) begin
      cycle();
      n++;
    end
    chk("idle_timeout", 32'(q_lo.size()), 32'd0);
  endtask

  initial begin
    bit pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_vec = '0; out_ready = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();

    // Mixed-bit vector drained at full rate.
    out_ready = 1'b1;
    capture(8'hA5);
    wait_idle();
    cycle();

    // Same vector with a stalling consumer.
    out_ready = 1'b0;
    capture(8'hA5);
    for (int k = 0; k < 6; k++) begin
      out_ready = pat[k];
      cycle();
    end
    wait_idle();

    // Empty vector.
    capture(8'h00);
    cycle();
    cycle();

    // Full vector aborted by dropping enable after three beats.
    out_ready = 1'b1;
    capture(8'hFF);
    cycle();
    cycle();
    cycle();
    en = 1'b0;
    cycle();
    en = 1'b1;
    cycle();
    capture(8'h10);
    wait_idle();
    cycle();

    // Reset in the middle of a scan.
    capture(8'hC3);
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    cycle();

    // Randomised traffic.
    for (int c = 0; c < 1500; c++) begin
      int mode;
      mode      = $urandom_range(0, 3);
      in_vec    = (mode == 0) ? 8'h00 :
                  (mode == 1) ? (8'h01 << $urandom_range(0, 7)) : 8'($urandom());
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 3) != 0);
      en        = ($urandom_range(0, 15) != 0);
      rst       = ($urandom_range(0, 63) == 0);
      cycle();
    end
    rst = 1'b0;
    en = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/onehot_scan_encoder.md
Name: onehot_scan_encoder

Overview:
- Parametrised, sequential successor to the team's 8-to-3 encoder. It is no longer restricted to one-hot input.
- Captures an N-bit request vector through a valid/ready handshake. Then emits the index of every set bit, one index per accepted output beat, in priority order.
- Provides population count, last-beat and empty-vector indications.
- Sits between interrupt/request sources and downstream dispatch logic that handles one request per transaction.

Parameters:
- N, 8, width of the request vector; power of two, at least 2.
- IDX_W, log2(N), width of the emitted index; derived, not overridden.
- MSB_FIRST, 0, 0 = emit lowest set index first; 1 = emit highest set index first.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- en, input, 1, block enable; low aborts any scan and blocks capture.
- in_vec, input, N, request vector; any number of bits may be set.
- in_valid, input, 1, in_vec is valid.
- in_ready, output, 1, block can capture a vector this cycle.
- out_idx, output, IDX_W, index of the current highest-priority pending bit.
- out_valid, output, 1, out_idx is valid.
- out_ready, input, 1, consumer accepts out_idx.
- out_last, output, 1, current beat is the final pending bit of this vector.
- out_none, output, 1, one-cycle pulse: the captured vector was all zeros.
- out_cnt, output, IDX_W+1, number of set bits in the last captured vector.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values (edge with rst=1): state=IDLE, pending=0, out_valid=0, out_last=0, out_none=0, out_cnt=0. out_idx reads 0 while out_valid=0.
- States: IDLE and SCAN.
- IDLE:
  - in_ready = en.
  - Capture happens on an edge with in_valid & in_ready.
  - If in_vec != 0: pending <= in_vec, out_cnt <= popcount(in_vec), state <= SCAN.
  - If in_vec == 0: out_cnt <= 0, out_none=1 for exactly the next cycle, state stays IDLE, no output beat.
- SCAN:
  - in_ready=0; no overlap with capture.
  - out_valid=1.
  - out_idx = index of the lowest set bit of pending (MSB_FIRST=0) or highest set bit (MSB_FIRST=1), decoded combinationally from the pending register.
  - out_last = (popcount(pending)==1).
- Output beat: occurs on an edge with out_valid & out_ready.
  - Clear bit out_idx in pending.
  - If out_last was 1, state <= IDLE.
  - If out_ready is low, out_idx/out_valid/out_last hold stable; no bit is dropped.
- Latency:
  - First out_valid is asserted the cycle after capture.
  - Back-to-back beats at one per cycle when out_ready is held high.
  - A K-bit vector takes K cycles in SCAN; in_ready returns the cycle after the last beat.
- Enable:
  - en=0 in IDLE: in_ready=0, nothing captured.
  - en=0 in SCAN: abort; pending <= 0 and state <= IDLE on that edge; out_valid is low the following cycle. A simultaneous out_ready on the abort edge is ignored by design.
  - out_cnt retains its value across an abort.
- Reset mid-scan: returns to the reset state on that edge, discarding pending.
- rst has priority over en, which has priority over the handshakes.
- Order, wrap and width rules:
  - The index order within one vector is strictly monotonic; no wrap-around.
  - out_cnt covers a value of N (all bits set), hence IDX_W+1 bits.
- Input changes: in_vec changes while in SCAN have no effect.
- X-propagation: out_idx must never be driven X.

Test Plan:
- rst=1 for 2 cycles, then release with en=1 -> all outputs at reset values, in_ready=1.
- N=8, MSB_FIRST=0, in_vec=8'b1010_0101 captured, out_ready=1 -> out_idx 0,2,5,7 on consecutive cycles; out_last only with 7; out_cnt=4; in_ready=1 on the next cycle.
- Same vector with MSB_FIRST=1 and out_ready toggling 1,0,1,1,0,1 -> out_idx sequence 7,5,2,0; each index held stable while out_ready=0.
- in_vec=8'h00 captured -> out_none=1 for one cycle, out_valid stays 0, out_cnt=0, in_ready stays 1.
- in_vec=8'hFF, en dropped after the 3rd beat -> out_valid=0 the next cycle, state IDLE; with en=1 again, a new vector 8'h10 yields the single beat out_idx=4 with out_last=1.
- rst asserted in SCAN mid-vector 8'hC3 -> reset values on the next cycle; no further beats.
